// File: rtl/core_rst_seq.sv
// Purpose : per-core clock-enable / reset sequencer; optional release stagger via CORE_RST_SEQ_STAGGER_EN.
// Latency : clk_en 2 edges after core_en_i rises, reset release RST_DELAY edges later; drain DRAIN_CYCLES.
// Backpr. : none on inputs; when staggered, saturated channels wait in CLK_UP for a grant.
module core_rst_seq #(
  parameter int NUM_CORES      = 4,
  parameter int RST_DELAY      = 8,
  parameter int DRAIN_CYCLES   = 4,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_CORES-1:0] core_en_i,
  output logic [NUM_CORES-1:0] clk_en_o,
  output logic [NUM_CORES-1:0] reset_core_n_o,
  output logic [NUM_CORES-1:0] core_running_o,
  output logic                 busy_o
);

  localparam int MAX_AB = (RST_DELAY > DRAIN_CYCLES) ? RST_DELAY : DRAIN_CYCLES;
  localparam int MAX_V  = (MAX_AB > STAGGER_CYCLES) ? MAX_AB : STAGGER_CYCLES;
  localparam int CW     = $clog2(MAX_V) + 1;

  localparam logic [CW-1:0] RST_MAX   = CW'(RST_DELAY - 1);
  localparam logic [CW-1:0] DRAIN_MAX = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_CLK_UP = 2'd1,
    ST_RUN    = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  logic [NUM_CORES-1:0]          sync1_q;
  logic [NUM_CORES-1:0]          en_s;
  state_t [NUM_CORES-1:0]        st_q;
  state_t [NUM_CORES-1:0]        st_d;
  logic [NUM_CORES-1:0][CW-1:0]  cnt_q;
  logic [NUM_CORES-1:0][CW-1:0]  cnt_d;
  logic [NUM_CORES-1:0]          grant;
  logic                          busy_d;
  logic                          busy_q;

  // Two-flop synchronizer for the asynchronous enable requests
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= '0;
      en_s    <= '0;
    end else begin
      sync1_q <= core_en_i;
      en_s    <= sync1_q;
    end
  end

`ifdef CORE_RST_SEQ_STAGGER_EN
  logic [NUM_CORES-1:0] sat;
  logic                 found;
  logic [CW-1:0]        stag_cnt;

  localparam logic [CW-1:0] STAG_MAX = CW'(STAGGER_CYCLES - 1);

  // Grant the lowest saturated CLK_UP channel, only when the spacing window has expired
  always_comb begin
    grant = '0;
    found = 1'b0;
    sat   = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      sat[n] = (st_q[n] == ST_CLK_UP) && (cnt_q[n] == RST_MAX);
      if (!found && sat[n] && (stag_cnt == '0)) begin
        grant[n] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Spacing window: reload on every grant, then count down to zero
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stag_cnt <= '0;
    end else if (|grant) begin
      stag_cnt <= STAG_MAX;
    end else if (stag_cnt != '0) begin
      stag_cnt <= stag_cnt - 1'b1;
    end
  end
`else
  // Without staggering every saturated channel may release at once
  always_comb begin
    grant = '1;
  end
`endif

  // State and counter registers; reset forces every channel straight to OFF
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      st_q   <= {NUM_CORES{ST_OFF}};
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // Next-state and counter logic per channel
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    busy_d = 1'b0;
    for (int n = 0; n < NUM_CORES; n++) begin
      case (st_q[n])
        ST_OFF: begin
          cnt_d[n] = '0;
          if (en_s[n]) st_d[n] = ST_CLK_UP;
        end
        ST_CLK_UP: begin
          if (!en_s[n]) begin
            st_d[n]  = ST_DRAIN;
            cnt_d[n] = '0;
          end else if ((cnt_q[n] == RST_MAX) && grant[n]) begin
            st_d[n]  = ST_RUN;
            cnt_d[n] = '0;
          end else if (cnt_q[n] != RST_MAX) begin
            cnt_d[n] = cnt_q[n] + 1'b1;
          end
        end
        ST_RUN: begin
          cnt_d[n] = '0;
          if (!en_s[n]) st_d[n] = ST_DRAIN;
        end
        ST_DRAIN: begin
          // A re-enable here is ignored; the drain always runs to OFF
          if (cnt_q[n] == DRAIN_MAX) begin
            st_d[n]  = ST_OFF;
            cnt_d[n] = '0;
          end else begin
            cnt_d[n] = cnt_q[n] + 1'b1;
          end
        end
        default: begin
          st_d[n]  = ST_OFF;
          cnt_d[n] = '0;
        end
      endcase
      // busy is registered from the next state so it tracks the state register exactly
      if ((st_d[n] == ST_CLK_UP) || (st_d[n] == ST_DRAIN)) busy_d = 1'b1;
    end
  end

  // Moore outputs decoded from registered state only
  always_comb begin
    clk_en_o       = '0;
    reset_core_n_o = '0;
    core_running_o = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      clk_en_o[n]       = (st_q[n] != ST_OFF);
      reset_core_n_o[n] = (st_q[n] == ST_RUN);
      core_running_o[n] = (st_q[n] == ST_RUN);
    end
  end

  assign busy_o = busy_q;

endmodule

// File: doc/core_rst_seq.md
# core_rst_seq

Parametrised per-core clock-enable and reset sequencer for a tile with `NUM_CORES` cores. It supersedes the single-core enable/reset controller in the tile. Each core has its own state machine that orders the events on power-up and power-down:
- Power-up: clock enable, then a reset hold period, then reset release.
- Power-down: reset assertion, then a drain period, then clock gating.

An optional stagger arbiter spreads reset releases across cores to limit inrush. The block sits between the tile control registers (`core_en_i`) and the per-core clock gates and reset inputs.

## Interface
- `NUM_CORES`, default 4: number of independent core channels, ≥1.
- `RST_DELAY`, default 8: cycles spent in CLK_UP (clock running, reset held) before release, ≥1.
- `DRAIN_CYCLES`, default 4: cycles spent in DRAIN (reset asserted, clock running) before gating, ≥1.
- `STAGGER_CYCLES`, default 16: minimum spacing between two reset releases when staggering is compiled in, ≥1.
- `clk_i` in, 1 bit: the single clock.
- `reset_i` in, 1 bit: reset, synchronous and active-high.
- `core_en_i` in, `NUM_CORES` bits: per-core enable request; asynchronous to `clk_i`.
- `clk_en_o` out, `NUM_CORES` bits: enable to the external clock gate of each core.
- `reset_core_n_o` out, `NUM_CORES` bits: active-low core reset.
- `core_running_o` out, `NUM_CORES` bits: high while the core is in RUN.
- `busy_o` out, 1 bit: high while any core is in CLK_UP or DRAIN.

## Operation
- Each bit of `core_en_i` passes through a 2-flop synchronizer (reset value 0), giving `en_s[n]`.
- Per-core state machine:
  - OFF: `clk_en_o`=0, `reset_core_n_o`=0. Goes to CLK_UP when `en_s`=1.
  - CLK_UP: `clk_en_o`=1, `reset_core_n_o`=0. The counter starts at 0 on entry and increments each cycle, saturating at `RST_DELAY-1`. If `en_s`=0, go to DRAIN. If the counter is `RST_DELAY-1` and the core is granted, go to RUN. Without staggering, the grant is always 1.
  - RUN: `clk_en_o`=1, `reset_core_n_o`=1, `core_running_o`=1. Goes to DRAIN when `en_s`=0.
  - DRAIN: `clk_en_o`=1, `reset_core_n_o`=0. The counter restarts at 0. After `DRAIN_CYCLES` cycles, go to OFF regardless of `en_s`.
- A re-enable during DRAIN is not aborted. The sequence completes to OFF and re-enters CLK_UP on the following cycle if `en_s`=1.
- Outputs are Moore and decoded from registered state only, so they are glitch-free toward the clock gates.
- Counter width is `$clog2(max(RST_DELAY, DRAIN_CYCLES, STAGGER_CYCLES))+1`. No counter ever wraps.
- Channels are fully independent apart from the optional stagger arbiter.
- `busy_o` is the registered OR over all channels of (state ∈ {CLK_UP, DRAIN}).

## Timing
- Reset values: while `reset_i`=1 and on the first edge after it, every channel is in OFF. All outputs are then 0: `clk_en_o`, `reset_core_n_o`, `core_running_o`, `busy_o`. Synchronizers and counters also clear.
- `reset_i` asserted mid-sequence, in any state, forces OFF on the next edge. There is no drain, and the reset output drops immediately.
- Enable latency: `core_en_i` rises before edge 0. `en_s`=1 after edge 1, `clk_en_o`=1 after edge 2, `reset_core_n_o`=1 after edge 2+`RST_DELAY` (no contention).
- Disable latency: `core_en_i` falls before edge 0. `reset_core_n_o`=0 after edge 2, and `clk_en_o`=0 after edge 2+`DRAIN_CYCLES`.
- `core_running_o` rises and falls on the same edge as `reset_core_n_o`.

## Configuration
- Macro: `CORE_RST_SEQ_STAGGER_EN`.
- Defined:
  - A shared down-counter `stag_cnt` (reset 0) gates reset releases.
  - A grant is given only when `stag_cnt`=0. It goes to the lowest-index channel in CLK_UP whose counter has saturated.
  - On a grant, `stag_cnt` loads `STAGGER_CYCLES-1`, then decrements to 0.
  - Channels that are not granted stay in CLK_UP with the counter saturated and `busy_o`=1.
  - At most one RUN entry occurs per `STAGGER_CYCLES` cycles.
- Undefined:
  - Grant is tied to 1 and there is no `stag_cnt`.
  - Simultaneous releases are allowed.

## Test plan
- After reset: raise `core_en_i[0]` at edge 0 with defaults. Required: `clk_en_o[0]`=1 after edge 2, `reset_core_n_o[0]`=1 after edge 10, `busy_o` high for edges 2–9.
- Drop `core_en_i[0]` from RUN. Required: reset is 0 after 2 edges, `clk_en_o[0]`=0 exactly 4 edges later, state OFF.
- Drop and re-raise `core_en_i[1]` within DRAIN. Required: drain completes, OFF for exactly 1 cycle, then CLK_UP and a full 8-cycle reset hold.
- With `CORE_RST_SEQ_STAGGER_EN`: raise all 4 enables in the same cycle. Required: releases for cores 0, 1, 2, 3 at edges 10, 26, 42, 58. Without the macro, all four release at edge 10.
- Assert `reset_i` for 1 cycle while core 2 is in RUN and core 3 is in DRAIN. Required: all outputs 0 after the next edge. Both cores restart from OFF through the synchronizer if their enables remain high.
